// File: rtl/hazard_interlock_pkg.sv
// hazard_interlock_pkg
//   Shared decode constants for the 5-stage pipeline hazard logic.
//   Opcode / ALU-op encodings, instruction field positions and the
//   interlock FSM state enum. The forwarding unit reuses these constants.
package hazard_interlock_pkg;

  // Opcode field [31:27]
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;

  // ALU op field [6:2] of R-type instructions
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  // Field slices
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int ALU_MSB = 6;
  localparam int ALU_LSB = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // True for an R-type mul or div.
  function automatic logic is_multdiv(input logic [4:0] opc, input logic [4:0] alu);
    return (opc == OP_RTYPE) && ((alu == ALU_MUL) || (alu == ALU_DIV));
  endfunction

endpackage

// File: rtl/hazard_interlock_if.sv
// hazard_interlock_if
//   Pipeline <-> interlock signal bundle.
//   master : pipeline side (drives IRs and multdiv status, consumes controls)
//   slave  : interlock side (hazard_interlock)
//   Signals: decodeIR/executeIR (F/D and D/X instructions), md_ready,
//   md_exception, ctrl_mult/ctrl_div start pulses, stall_fd, stall_dx,
//   bubble_dx, bubble_xm, md_result_sel, md_exception_out, md_rd, md_busy.
interface hazard_interlock_if;
  logic [31:0] decodeIR;
  logic [31:0] executeIR;
  logic        md_ready;
  logic        md_exception;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall_fd;
  logic        stall_dx;
  logic        bubble_dx;
  logic        bubble_xm;
  logic        md_result_sel;
  logic        md_exception_out;
  logic [4:0]  md_rd;
  logic        md_busy;

  modport master (
    output decodeIR, executeIR, md_ready, md_exception,
    input  ctrl_mult, ctrl_div, stall_fd, stall_dx, bubble_dx, bubble_xm,
           md_result_sel, md_exception_out, md_rd, md_busy
  );

  modport slave (
    input  decodeIR, executeIR, md_ready, md_exception,
    output ctrl_mult, ctrl_div, stall_fd, stall_dx, bubble_dx, bubble_xm,
           md_result_sel, md_exception_out, md_rd, md_busy
  );
endinterface

// File: rtl/hazard_interlock_src_decode.sv
// hazard_src_decode
//   Combinational source-register decode of one instruction.
//   ir           : instruction word
//   src_a/vld_a  : first source register and whether it is really read
//   src_b/vld_b  : second source register and whether it is really read
//   r0 is never reported as a valid source (it cannot carry a hazard).
module hazard_src_decode
  import hazard_interlock_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  src_a,
  output logic        vld_a,
  output logic [4:0]  src_b,
  output logic        vld_b
);

  logic [4:0] opc, rd, rs, rt;
  logic       raw_a, raw_b;
  logic       unused_ir;

  assign opc = ir[OPC_MSB:OPC_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign rs  = ir[RS_MSB:RS_LSB];
  assign rt  = ir[RT_MSB:RT_LSB];
  assign unused_ir = ^ir[RT_LSB-1:0];

  always_comb begin
    src_a = rs;
    src_b = rt;
    raw_a = 1'b0;
    raw_b = 1'b0;
    case (opc)
      OP_RTYPE: begin
        raw_a = 1'b1;
        raw_b = 1'b1;
      end
      // sw data register (rd) is covered by dmem forwarding, only the base counts
      OP_ADDI, OP_LW, OP_SW: raw_a = 1'b1;
      OP_BNE, OP_BLT: begin
        src_a = rd;
        src_b = rs;
        raw_a = 1'b1;
        raw_b = 1'b1;
      end
      OP_JR: begin
        src_a = rd;
        raw_a = 1'b1;
      end
      default: ;
    endcase
  end

  assign vld_a = raw_a && (src_a != 5'd0);
  assign vld_b = raw_b && (src_b != 5'd0);

endmodule

// File: rtl/hazard_interlock.sv
// hazard_interlock
//   Stall/interlock controller for the 5-stage pipeline.
//   - Load-use: lw in X whose rd is read by the D instruction -> one bubble
//     into D/X while PC and F/D hold.
//   - Mult/div in X: one-cycle start pulse, then freeze the front end in WAIT
//     until md_ready (or watchdog expiry), then release result into X/M.
//   Ports: clock, reset (synchronous, active high), bus (hazard_interlock_if.slave).
//   Optional feature macro HAZARD_PERF_EN adds saturating stall counters
//   lu_stall_count / md_stall_count.
//   Outputs are combinational from the registered state plus inputs and are
//   forced to 0 while reset is asserted.
module hazard_interlock
  import hazard_interlock_pkg::*;
#(
  parameter logic [4:0] STATUS_REG    = 5'd30,
  parameter int         MD_MAX_CYCLES = 40
) (
  input  logic                 clock,
  input  logic                 reset,
  hazard_interlock_if.slave    bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          lu_stall_count,
  output logic [31:0]          md_stall_count
`endif
);

  localparam int               WD_W     = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(MD_MAX_CYCLES - 1);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [4:0]      md_rd_q, md_rd_d;

  // X-stage fields
  logic [4:0] x_opc, x_rd, x_alu;
  logic       x_md, x_lw;
  logic       unused_x;

  assign x_opc    = bus.executeIR[OPC_MSB:OPC_LSB];
  assign x_rd     = bus.executeIR[RD_MSB:RD_LSB];
  assign x_alu    = bus.executeIR[ALU_MSB:ALU_LSB];
  assign x_md     = is_multdiv(x_opc, x_alu);
  assign x_lw     = (x_opc == OP_LW) && (x_rd != 5'd0);
  assign unused_x = ^{bus.executeIR[RS_MSB:ALU_MSB+1], bus.executeIR[ALU_LSB-1:0]};

  // D-stage sources
  logic [4:0] d_src_a, d_src_b;
  logic       d_vld_a, d_vld_b, load_use;

  hazard_src_decode u_dec (
    .ir    (bus.decodeIR),
    .src_a (d_src_a),
    .vld_a (d_vld_a),
    .src_b (d_src_b),
    .vld_b (d_vld_b)
  );

  assign load_use = x_lw && ((d_vld_a && (d_src_a == x_rd)) ||
                             (d_vld_b && (d_src_b == x_rd)));

  logic       mult_c, div_c, sfd_c, sdx_c, bdx_c, bxm_c, rsel_c, exc_c, busy_c;
  logic [4:0] rd_c;
  logic       lu_evt, md_evt;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    md_rd_d = md_rd_q;
    mult_c  = 1'b0;
    div_c   = 1'b0;
    sfd_c   = 1'b0;
    sdx_c   = 1'b0;
    bdx_c   = 1'b0;
    bxm_c   = 1'b0;
    rsel_c  = 1'b0;
    exc_c   = 1'b0;
    busy_c  = 1'b0;
    rd_c    = md_rd_q;
    lu_evt  = 1'b0;
    md_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        // md_ready is ignored here: a stale ready after reset must not release
        if (x_md) begin
          mult_c  = (x_alu == ALU_MUL);
          div_c   = (x_alu == ALU_DIV);
          sfd_c   = 1'b1;
          sdx_c   = 1'b1;
          bxm_c   = 1'b1;
          rd_c    = x_rd;
          md_rd_d = x_rd;
          wd_d    = '0;
          md_evt  = 1'b1;
          state_d = WAIT;
        end else if (load_use) begin
          // one bubble suffices: next cycle the lw has moved on to M
          sfd_c  = 1'b1;
          bdx_c  = 1'b1;
          lu_evt = 1'b1;
        end
      end
      WAIT: begin
        busy_c = 1'b1;
        if (bus.md_ready || (wd_q == WD_LIMIT)) begin
          // watchdog expiry completes as an exception
          rsel_c  = 1'b1;
          exc_c   = bus.md_ready ? bus.md_exception : 1'b1;
          rd_c    = exc_c ? STATUS_REG : md_rd_q;
          state_d = IDLE;
        end else begin
          sfd_c  = 1'b1;
          sdx_c  = 1'b1;
          bxm_c  = 1'b1;
          wd_d   = wd_q + WD_W'(1);
          md_evt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wd_q    <= '0;
      md_rd_q <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      md_rd_q <= md_rd_d;
    end
  end

  assign bus.ctrl_mult        = mult_c & ~reset;
  assign bus.ctrl_div         = div_c  & ~reset;
  assign bus.stall_fd         = sfd_c  & ~reset;
  assign bus.stall_dx         = sdx_c  & ~reset;
  assign bus.bubble_dx        = bdx_c  & ~reset;
  assign bus.bubble_xm        = bxm_c  & ~reset;
  assign bus.md_result_sel    = rsel_c & ~reset;
  assign bus.md_exception_out = exc_c  & ~reset;
  assign bus.md_busy          = busy_c & ~reset;
  assign bus.md_rd            = reset ? 5'd0 : rd_c;

`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt_q, lu_cnt_d, md_cnt_q, md_cnt_d;

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    md_cnt_d = md_cnt_q;
    if (lu_evt && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + 32'd1;
    if (md_evt && (md_cnt_q != '1)) md_cnt_d = md_cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lu_cnt_q <= '0;
      md_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign lu_stall_count = lu_cnt_q;
  assign md_stall_count = md_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = lu_evt ^ md_evt;
`endif

endmodule

// File: tb/tb_hazard_interlock.sv
// tb_hazard_interlock
//   Directed vector table + watchdog sequence, then randomized stimulus
//   against a behavioural reference model of the interlock rules.
module tb_hazard_interlock;
  import hazard_interlock_pkg::*;

  localparam int         MAXC   = 40;
  localparam logic [4:0] STATUS = 5'd30;
  localparam logic [4:0] ALU_ADD = 5'b00000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_interlock_if bus();
`ifdef HAZARD_PERF_EN
  logic [31:0] lu_cnt, md_cnt;
`endif

  hazard_interlock #(.STATUS_REG(STATUS), .MD_MAX_CYCLES(MAXC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef HAZARD_PERF_EN
    ,
    .lu_stall_count (lu_cnt),
    .md_stall_count (md_cnt)
`endif
  );

  typedef struct packed {
    logic       mult, div, sfd, sdx, bdx, bxm, rsel, exc;
    logic [4:0] rd;
    logic       busy;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] d, x;
    logic        rdy, exc;
    out_t        exp;
  } vec_t;

  vec_t tv[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] r_ins(logic [4:0] alu, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction
  function automatic logic [31:0] i_ins(logic [4:0] op, logic [4:0] rd, logic [4:0] rs, logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic out_t mk(bit mult, bit div, bit sfd, bit sdx, bit bdx, bit bxm,
                              bit rsel, bit exc, logic [4:0] rd, bit busy);
    out_t o;
    o.mult = mult; o.div = div; o.sfd = sfd; o.sdx = sdx; o.bdx = bdx; o.bxm = bxm;
    o.rsel = rsel; o.exc = exc; o.rd = rd; o.busy = busy;
    return o;
  endfunction

  // ---------------- reference model ----------------
  bit         m_busy = 0;
  int         m_waited = 0;
  logic [4:0] m_rd = '0;
  longint     m_lu = 0, m_md = 0;

  function automatic bit reads(logic [31:0] ir, logic [4:0] r);
    logic [4:0] op, rd, rs, rt;
    op = ir[31:27]; rd = ir[26:22]; rs = ir[21:17]; rt = ir[16:12];
    if (r == 5'd0) return 0;
    if (op == 5'b00000) return (rs == r) || (rt == r);
    if (op == 5'b00101 || op == 5'b01000 || op == 5'b00111) return rs == r;
    if (op == 5'b00010 || op == 5'b00110) return (rd == r) || (rs == r);
    if (op == 5'b00100) return rd == r;
    return 0;
  endfunction

  task automatic model_step(input logic rst, input logic [31:0] d, input logic [31:0] x,
                            input logic rdy, input logic exc, output out_t e);
    logic [4:0] xop, xrd, xalu;
    xop = x[31:27]; xrd = x[26:22]; xalu = x[6:2];
    e = '0;
    if (rst) begin
      m_busy = 0; m_waited = 0; m_rd = '0; m_lu = 0; m_md = 0;
    end else if (!m_busy) begin
      e.rd = m_rd;
      if (xop == 5'b00000 && (xalu == 5'b00110 || xalu == 5'b00111)) begin
        e.mult = (xalu == 5'b00110);
        e.div  = (xalu == 5'b00111);
        e.sfd = 1; e.sdx = 1; e.bxm = 1;
        e.rd = xrd;
        m_rd = xrd; m_busy = 1; m_waited = 0; m_md++;
      end else if (xop == 5'b01000 && xrd != 0 && reads(d, xrd)) begin
        e.sfd = 1; e.bdx = 1; m_lu++;
      end
    end else begin
      e.busy = 1;
      if (rdy || (m_waited + 1 >= MAXC)) begin
        e.rsel = 1;
        e.exc  = rdy ? exc : 1'b1;
        e.rd   = e.exc ? STATUS : m_rd;
        m_busy = 0;
      end else begin
        e.sfd = 1; e.sdx = 1; e.bxm = 1; e.rd = m_rd;
        m_waited++; m_md++;
      end
    end
  endtask

  function automatic out_t dut_out();
    out_t o;
    o.mult = bus.ctrl_mult; o.div = bus.ctrl_div; o.sfd = bus.stall_fd; o.sdx = bus.stall_dx;
    o.bdx = bus.bubble_dx; o.bxm = bus.bubble_xm; o.rsel = bus.md_result_sel;
    o.exc = bus.md_exception_out; o.rd = bus.md_rd; o.busy = bus.md_busy;
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (m,d,sfd,sdx,bdx,bxm,rsel,exc,rd[5],busy)", name, got, exp);
  endtask

  // Drive one cycle, check outputs at the negedge, then advance the model.
  task automatic apply(input vec_t v, input bit use_model);
    out_t me;
    @(posedge clock); #1;
    reset = v.rst;
    bus.decodeIR = v.d; bus.executeIR = v.x;
    bus.md_ready = v.rdy; bus.md_exception = v.exc;
    @(negedge clock);
`ifdef HAZARD_PERF_EN
    n_chk++;
    if (lu_cnt === 32'(m_lu) && md_cnt === 32'(m_md)) n_pass++;
    else $display("FAIL %s perf: got lu=%0d md=%0d expected lu=%0d md=%0d", v.name, lu_cnt, md_cnt, m_lu, m_md);
`endif
    model_step(v.rst, v.d, v.x, v.rdy, v.exc, me);
    check(v.name, dut_out(), use_model ? me : v.exp);
  endtask

  task automatic add(input string n, input logic rst, input logic [31:0] d, input logic [31:0] x,
                     input logic rdy, input logic exc, input out_t e);
    vec_t v;
    v.name = n; v.rst = rst; v.d = d; v.x = x; v.rdy = rdy; v.exc = exc; v.exp = e;
    tv.push_back(v);
  endtask

  function automatic logic [31:0] rand_ir();
    logic [4:0] ops[8];
    logic [4:0] op;
    logic [31:0] ir;
    ops = '{5'b00000, 5'b00101, 5'b01000, 5'b00111, 5'b00010, 5'b00110, 5'b00100, 5'b10101};
    op = ops[$urandom_range(0, 7)];
    ir = $urandom;
    ir[31:27] = op;
    ir[26:22] = 5'($urandom_range(0, 3));
    ir[21:17] = 5'($urandom_range(0, 3));
    ir[16:12] = 5'($urandom_range(0, 3));
    return ir;
  endfunction

  logic [31:0] NOP, LW5, ADD_R5, MUL3;
  out_t Z;

  initial begin
    vec_t v;
    NOP    = 32'h0;
    LW5    = i_ins(OP_LW, 5'd5, 5'd2, 17'd0);
    ADD_R5 = r_ins(ALU_ADD, 5'd6, 5'd5, 5'd1);
    MUL3   = r_ins(ALU_MUL, 5'd3, 5'd1, 5'd2);
    Z      = '0;

    reset = 1'b1;
    bus.decodeIR = '0; bus.executeIR = '0; bus.md_ready = 1'b0; bus.md_exception = 1'b0;
    repeat (2) @(posedge clock);

    // name, rst, decodeIR, executeIR, rdy, exc, expected
    add("rst_gates_outputs", 1, NOP, MUL3, 1, 1, Z);
    add("lu_rs", 0, ADD_R5, LW5, 0, 0, mk(0,0,1,0,1,0,0,0,0,0));
    add("lu_one_bubble", 0, ADD_R5, NOP, 0, 0, Z);
    add("lw_r0", 0, r_ins(ALU_ADD, 6, 0, 1), i_ins(OP_LW, 0, 2, 0), 0, 0, Z);
    add("sw_data_exempt", 0, i_ins(OP_SW, 5, 3, 0), LW5, 0, 0, Z);
    add("sw_base", 0, i_ins(OP_SW, 6, 5, 0), LW5, 0, 0, mk(0,0,1,0,1,0,0,0,0,0));
    add("bne_rd", 0, i_ins(OP_BNE, 5, 7, 0), LW5, 0, 0, mk(0,0,1,0,1,0,0,0,0,0));
    add("jr_rd", 0, i_ins(OP_JR, 5, 0, 0), LW5, 0, 0, mk(0,0,1,0,1,0,0,0,0,0));
    add("addi_imm_not_src", 0, i_ins(OP_ADDI, 6, 2, {5'd5, 12'h000}), LW5, 0, 0, Z);
    add("lu_rt", 0, r_ins(ALU_ADD, 6, 1, 5), LW5, 0, 0, mk(0,0,1,0,1,0,0,0,0,0));
    add("mul_start", 0, NOP, MUL3, 1, 1, mk(1,0,1,1,0,1,0,0,3,0));
    add("mul_wait1", 0, NOP, MUL3, 0, 0, mk(0,0,1,1,0,1,0,0,3,1));
    add("wait_no_lu", 0, ADD_R5, LW5, 0, 0, mk(0,0,1,1,0,1,0,0,3,1));
    add("mul_wait3", 0, NOP, MUL3, 0, 0, mk(0,0,1,1,0,1,0,0,3,1));
    add("mul_release", 0, NOP, MUL3, 1, 0, mk(0,0,0,0,0,0,1,0,3,1));
    add("div_b2b_start", 0, NOP, r_ins(ALU_DIV, 4, 1, 0), 0, 0, mk(0,1,1,1,0,1,0,0,4,0));
    add("div_wait", 0, NOP, r_ins(ALU_DIV, 4, 1, 0), 0, 0, mk(0,0,1,1,0,1,0,0,4,1));
    add("div_exc", 0, NOP, r_ins(ALU_DIV, 4, 1, 0), 1, 1, mk(0,0,0,0,0,0,1,1,STATUS,1));
    add("idle_after_div", 0, NOP, NOP, 0, 0, mk(0,0,0,0,0,0,0,0,4,0));
    add("mul7_start", 0, NOP, r_ins(ALU_MUL, 7, 1, 2), 0, 0, mk(1,0,1,1,0,1,0,0,7,0));
    add("mul7_wait1", 0, NOP, r_ins(ALU_MUL, 7, 1, 2), 0, 0, mk(0,0,1,1,0,1,0,0,7,1));
    add("rst_mid_wait", 1, NOP, r_ins(ALU_MUL, 7, 1, 2), 0, 0, Z);
    add("stale_ready", 0, NOP, NOP, 1, 0, Z);
    add("lu_after_rst", 0, ADD_R5, LW5, 1, 0, mk(0,0,1,0,1,0,0,0,0,0));

    foreach (tv[i]) apply(tv[i], 1'b0);

    // Watchdog: md_ready never arrives, 40th WAIT cycle completes as exception.
    v.rst = 0; v.d = NOP; v.rdy = 0; v.exc = 0;
    v.x = r_ins(ALU_MUL, 9, 1, 2);
    v.name = "wd_start"; v.exp = mk(1,0,1,1,0,1,0,0,9,0); apply(v, 1'b0);
    for (int i = 1; i < MAXC; i++) begin
      v.name = $sformatf("wd_wait%0d", i); v.exp = mk(0,0,1,1,0,1,0,0,9,1); apply(v, 1'b0);
    end
    v.name = "wd_forced"; v.exp = mk(0,0,0,0,0,0,1,1,STATUS,1); apply(v, 1'b0);
    v.x = NOP;
    v.name = "wd_idle"; v.exp = mk(0,0,0,0,0,0,0,0,9,0); apply(v, 1'b0);

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      v.name = $sformatf("rand%0d", i);
      v.rst = ($urandom_range(0, 149) == 0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      v.x = r_ins(ALU_MUL, 5'($urandom_range(0, 7)), 1, 2);
      else if (sel == 1) v.x = r_ins(ALU_DIV, 5'($urandom_range(0, 7)), 1, 2);
      else if (sel < 6)  v.x = i_ins(OP_LW, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 17'($urandom));
      else               v.x = rand_ir();
      v.d   = rand_ir();
      v.rdy = ($urandom_range(0, 15) == 0);
      v.exc = 1'($urandom);
      v.exp = '0;
      apply(v, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
